// File: rtl/time_entry.sv
// Minute/second entry front end: synchronizes and debounces two buttons,
// walks through minute then second BCD entry and emits a one-cycle load.
module time_entry #(
  parameter int DB_COUNT = 500000,
  parameter int DB_W     = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic [1:0] btn,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       load,
  output logic       editing,
  output logic [1:0] field,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EDIT_MIN = 2'd1,
    S_EDIT_SEC = 2'd2,
    S_COMMIT   = 2'd3
  } state_t;

  logic [1:0]      r_btn_s1;
  logic [1:0]      r_btn_s2;
  logic [7:0]      r_sw_s1;
  logic [7:0]      r_sw_s2;
  logic [1:0]      r_stable;
  logic [1:0]      r_stable_d;
  logic [1:0]      r_press;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t          r_state;
  state_t          w_state_next;
  logic [5:0]      r_min_stage;
  logic [5:0]      r_sec_stage;
  logic [5:0]      r_minute;
  logic [5:0]      r_second;
  logic            r_load;
  logic            r_err;
  logic            r_editing;
  logic [1:0]      r_field;

  logic            w_enter;
  logic            w_cancel;
  logic [3:0]      w_tens;
  logic [3:0]      w_units;
  logic            w_valid;
  logic [6:0]      w_sum7;
  logic [5:0]      w_value;
  logic            w_err_next;
  logic            w_min_we;
  logic            w_sec_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
      r_sw_s1    <= '0;
      r_sw_s2    <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
    end else begin
      r_btn_s1   <= btn;
      r_btn_s2   <= r_btn_s1;
      r_sw_s1    <= sw;
      r_sw_s2    <= r_sw_s1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
    end
  end

  // One debouncer per button; the level is accepted only after DB_COUNT
  // consecutive cycles of disagreement with the current stable level.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_db_cnt[gi] <= '0;
          r_stable[gi] <= 1'b0;
        end else if (r_btn_s2[gi] == r_stable[gi]) begin
          r_db_cnt[gi] <= '0;
        end else if (r_db_cnt[gi] == DB_W'(DB_COUNT - 1)) begin
          r_stable[gi] <= r_btn_s2[gi];
          r_db_cnt[gi] <= '0;
        end else begin
          r_db_cnt[gi] <= r_db_cnt[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign w_enter  = r_press[0];
  assign w_cancel = r_press[1];
  assign w_tens   = r_sw_s2[7:4];
  assign w_units  = r_sw_s2[3:0];
  assign w_valid  = (w_tens <= 4'd5) && (w_units <= 4'd9);
  assign w_sum7   = ({3'b000, w_tens} << 3) + ({3'b000, w_tens} << 1) + {3'b000, w_units};
  assign w_value  = w_sum7[5:0];

  // Cancel takes priority over enter when both pulse together.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    w_min_we     = 1'b0;
    w_sec_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_enter && !w_cancel) w_state_next = S_EDIT_MIN;
      end
      S_EDIT_MIN: begin
        if (w_cancel) begin
          w_state_next = S_IDLE;
        end else if (w_enter) begin
          if (w_valid) begin
            w_min_we     = 1'b1;
            w_state_next = S_EDIT_SEC;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      S_EDIT_SEC: begin
        if (w_cancel) begin
          w_state_next = S_IDLE;
        end else if (w_enter) begin
          if (w_valid) begin
            w_sec_we     = 1'b1;
            w_state_next = S_COMMIT;
          end else begin
            w_err_next = 1'b1;
          end
        end
      end
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_min_stage <= '0;
      r_sec_stage <= '0;
      r_minute    <= '0;
      r_second    <= '0;
      r_load      <= 1'b0;
      r_err       <= 1'b0;
      r_editing   <= 1'b0;
      r_field     <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      if (w_min_we) r_min_stage <= w_value;
      if (w_sec_we) r_sec_stage <= w_value;
      // load rises together with the new minute/second values
      r_load <= (r_state == S_COMMIT);
      if (r_state == S_COMMIT) begin
        r_minute <= r_min_stage;
        r_second <= r_sec_stage;
      end
      r_editing <= (w_state_next == S_EDIT_MIN) || (w_state_next == S_EDIT_SEC);
      case (w_state_next)
        S_EDIT_MIN: r_field <= 2'b01;
        S_EDIT_SEC: r_field <= 2'b10;
        default:    r_field <= 2'b00;
      endcase
    end
  end

  assign minute  = r_minute;
  assign second  = r_second;
  assign load    = r_load;
  assign err     = r_err;
  assign editing = r_editing;
  assign field   = r_field;

endmodule

// File: tb/tb_time_entry.sv
// Self-checking bench for time_entry: vector table of button presses plus
// hand-written sequences, with a queue scoreboard for committed values.
module tb_time_entry;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [1:0] btn;
  logic [5:0] minute;
  logic [5:0] second;
  logic       load;
  logic       editing;
  logic [1:0] field;
  logic       err;

  int total = 0;
  int bad   = 0;
  int err_seen = 0;

  typedef struct {
    logic [7:0] sw;
    logic [1:0] btn;
    int         exp_err;
    logic [1:0] exp_field;
    bit         push;
    logic [5:0] exp_min;
    logic [5:0] exp_sec;
  } vec_t;

  logic [11:0] sb_q[$];
  vec_t        vecs[17];

  time_entry #(.DB_COUNT(4), .DB_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn(btn),
    .minute(minute), .second(second), .load(load),
    .editing(editing), .field(field), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] s, input logic [1:0] b, input int e,
                              input logic [1:0] f, input bit p, input int m, input int sc);
    vec_t v;
    v.sw = s; v.btn = b; v.exp_err = e; v.exp_field = f; v.push = p;
    v.exp_min = 6'(m); v.exp_sec = 6'(sc);
    return v;
  endfunction

  // Scoreboard: every load must match the next queued commit.
  always @(negedge clk) begin
    if (err) err_seen++;
    if (load && err) check("load_err_overlap", 1, 0);
    if (load) begin
      if (sb_q.size() == 0) begin
        check("unexpected_load", 1, 0);
      end else begin
        logic [11:0] e;
        e = sb_q.pop_front();
        check("load_minute", int'(minute), int'(e[11:6]));
        check("load_second", int'(second), int'(e[5:0]));
        $display("load observed minute=%0d second=%0d", minute, second);
      end
    end
  end

  task automatic press(input logic [1:0] b);
    @(negedge clk) btn = b;
    repeat (10) @(negedge clk);
    btn = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic entry(input logic [7:0] s, input logic [1:0] b, input int exp_err,
                       input logic [1:0] exp_field, input string tag);
    int e0;
    sw = s;
    e0 = err_seen;
    press(b);
    check({tag, "_err"}, err_seen - e0, exp_err);
    check({tag, "_field"}, int'(field), int'(exp_field));
    $display("entry %s sw=%02h btn=%b err=%0d field=%b", tag, s, b, err_seen - e0, field);
  endtask

  initial begin
    rst_n = 1'b0; btn = 2'b00; sw = 8'h00;

    vecs[0]  = mk(8'h42, 2'b01, 0, 2'b10, 0,  0,  0);
    vecs[1]  = mk(8'h37, 2'b01, 0, 2'b00, 1, 42, 37);
    vecs[2]  = mk(8'h99, 2'b01, 0, 2'b01, 0,  0,  0);
    vecs[3]  = mk(8'h60, 2'b01, 1, 2'b01, 0,  0,  0);
    vecs[4]  = mk(8'h0A, 2'b01, 1, 2'b01, 0,  0,  0);
    vecs[5]  = mk(8'h59, 2'b01, 0, 2'b10, 0,  0,  0);
    vecs[6]  = mk(8'h6F, 2'b01, 1, 2'b10, 0,  0,  0);
    vecs[7]  = mk(8'h00, 2'b01, 0, 2'b00, 1, 59,  0);
    vecs[8]  = mk(8'h00, 2'b01, 0, 2'b01, 0,  0,  0);
    vecs[9]  = mk(8'h10, 2'b01, 0, 2'b10, 0,  0,  0);
    vecs[10] = mk(8'h20, 2'b01, 0, 2'b00, 1, 10, 20);
    vecs[11] = mk(8'h00, 2'b01, 0, 2'b01, 0,  0,  0);
    vecs[12] = mk(8'h05, 2'b01, 0, 2'b10, 0,  0,  0);
    vecs[13] = mk(8'h07, 2'b10, 0, 2'b00, 0,  0,  0);
    vecs[14] = mk(8'h00, 2'b01, 0, 2'b01, 0,  0,  0);
    vecs[15] = mk(8'h12, 2'b11, 0, 2'b00, 0,  0,  0);
    vecs[16] = mk(8'h34, 2'b10, 0, 2'b00, 0,  0,  0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_minute", int'(minute), 0);
    check("rst_second", int'(second), 0);
    check("rst_load", int'(load), 0);
    check("rst_err", int'(err), 0);
    check("rst_field", int'(field), 0);
    check("rst_editing", int'(editing), 0);
    rst_n = 1'b1;

    // Cancel held in IDLE does nothing
    @(negedge clk) btn = 2'b10;
    repeat (20) @(negedge clk);
    check("idle_cancel_field", int'(field), 0);
    btn = 2'b00;
    repeat (10) @(negedge clk);

    // Short glitch rejected
    btn = 2'b01;
    repeat (3) @(negedge clk);
    btn = 2'b00;
    repeat (20) @(negedge clk);
    check("glitch_field", int'(field), 0);
    $display("glitch field=%b", field);

    // Press latency: field still 00 after 7 edges, 01 after the 8th
    btn = 2'b01;
    repeat (7) @(negedge clk);
    check("latency_early_field", int'(field), 0);
    @(negedge clk);
    check("latency_field", int'(field), 1);
    check("latency_editing", int'(editing), 1);
    repeat (12) @(negedge clk);
    btn = 2'b00;
    repeat (10) @(negedge clk);
    $display("latency field=%b editing=%b", field, editing);

    // Table-driven entries starting in EDIT_MIN
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].push) sb_q.push_back({vecs[i].exp_min, vecs[i].exp_sec});
      entry(vecs[i].sw, vecs[i].btn, vecs[i].exp_err, vecs[i].exp_field, $sformatf("vec%0d", i));
    end
    check("hold_minute", int'(minute), 10);
    check("hold_second", int'(second), 20);

    // Reset mid-edit discards the staged minute
    entry(8'h00, 2'b01, 0, 2'b01, "pre_rst_enter");
    entry(8'h33, 2'b01, 0, 2'b10, "pre_rst_min");
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    check("midrst_field", int'(field), 0);
    check("midrst_minute", int'(minute), 0);
    check("midrst_second", int'(second), 0);
    repeat (10) @(negedge clk);
    check("midrst_field_later", int'(field), 0);
    entry(8'h00, 2'b01, 0, 2'b01, "post_rst_enter");
    entry(8'h00, 2'b01, 0, 2'b10, "post_rst_min");
    sb_q.push_back(12'h000);
    entry(8'h00, 2'b01, 0, 2'b00, "post_rst_sec");

    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
